// File: rtl/mem_op_collector.sv
`default_nettype none
// ============================================================================
// Module   : mem_op_collector
// Purpose  : Merges core requests and resend-queue entries into the memOp
//            queue, packs the 8 flush data words into two 128-bit write-data
//            beats, and diverts non-Address resend entries to the ring
//            message output.
// Revision : 1.0 - initial release
// ============================================================================
module mem_op_collector #(
  parameter logic [3:0] ADDRESS_TYPE = 4'd1,
  parameter bit         RESEND_FIRST = 1'b1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         reqEmpty,
  output logic         rdReq,
  input  logic [3:0]   reqSrc,
  input  logic [31:0]  reqData,
  input  logic         resendEmpty,
  output logic         rdResend,
  input  logic [39:0]  resendIn,
  input  logic         memOpQfull,
  output logic         wrMemOp,
  output logic [35:0]  memOpOut,
  input  logic         writeDataQfull,
  output logic         wrWriteData,
  output logic [127:0] writeDataOut,
  input  logic         msgFull,
  output logic         wrMsg,
  output logic [39:0]  msgOut
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } state_t;

  state_t       r_state;
  logic [2:0]   r_count;
  logic [3:0]   r_flushSrc;
  logic [95:0]  r_beat;         // lanes 0..2; lane 3 goes straight to the output
  logic         r_favourResend;

  logic w_idle;
  logic w_collect;
  logic w_resendIsAddr;
  logic w_resendCand;
  logic w_reqCand;
  logic w_grantResend;
  logic w_grantReq;
  logic w_laneLast;
  logic w_takeWord;

  // Candidate qualification and arbitration; pops are suppressed while in
  // reset so no upstream entry is consumed without being forwarded.
  assign w_idle         = (r_state == ST_IDLE);
  assign w_collect      = (r_state == ST_COLLECT);
  assign w_resendIsAddr = (resendIn[35:32] == ADDRESS_TYPE);
  assign w_resendCand   = !resendEmpty && (w_resendIsAddr ? !memOpQfull : !msgFull);
  assign w_reqCand      = !reqEmpty && !memOpQfull;
  assign w_grantResend  = reset && w_idle && w_resendCand && (!w_reqCand || r_favourResend);
  assign w_grantReq     = reset && w_idle && w_reqCand && !w_grantResend;
  assign w_laneLast     = (r_count[1:0] == 2'd3);
  // A word from a foreign source is never popped: the block stalls on it.
  assign w_takeWord     = reset && w_collect && !reqEmpty && (reqSrc == r_flushSrc)
                          && (!w_laneLast || !writeDataQfull);

  assign rdReq    = w_grantReq || w_takeWord;
  assign rdResend = w_grantResend;

  // Main FSM: registered push strobes/data, flush word collection, pointer.
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state        <= ST_IDLE;
      r_count        <= 3'd0;
      r_flushSrc     <= 4'd0;
      r_beat         <= 96'd0;
      r_favourResend <= RESEND_FIRST;
      wrMemOp        <= 1'b0;
      memOpOut       <= 36'd0;
      wrWriteData    <= 1'b0;
      writeDataOut   <= 128'd0;
      wrMsg          <= 1'b0;
      msgOut         <= 40'd0;
    end else begin
      wrMemOp     <= 1'b0;
      wrWriteData <= 1'b0;
      wrMsg       <= 1'b0;

      if (w_grantResend) begin
        r_favourResend <= ~r_favourResend;
        if (w_resendIsAddr) begin
          wrMemOp  <= 1'b1;
          memOpOut <= {resendIn[39:36], resendIn[31:0]};
        end else begin
          wrMsg  <= 1'b1;
          msgOut <= resendIn;
        end
      end

      if (w_grantReq) begin
        r_favourResend <= ~r_favourResend;
        wrMemOp        <= 1'b1;
        memOpOut       <= {reqSrc, reqData};
        if (!reqData[28]) begin
          r_state    <= ST_COLLECT;
          r_count    <= 3'd0;
          r_flushSrc <= reqSrc;
        end
      end

      if (w_takeWord) begin
        r_count <= r_count + 3'd1;
        case (r_count[1:0])
          2'd0: r_beat[31:0]  <= reqData;
          2'd1: r_beat[63:32] <= reqData;
          2'd2: r_beat[95:64] <= reqData;
          default: begin
            wrWriteData  <= 1'b1;
            writeDataOut <= {reqData, r_beat};
          end
        endcase
        if (r_count == 3'd7) begin
          r_state        <= ST_IDLE;
          r_favourResend <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire
